// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers: depth derivation and Gray/binary conversion,
// used by both the write-side and read-side pointer/flag blocks.
package fifo_pkg;

    // Widest pointer the helpers handle; callers zero-extend into this word
    // and truncate the result back to their own pointer width.
    localparam int PTR_MAX_W = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_word_t;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    function automatic ptr_word_t bin2gray(input ptr_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Prefix XOR from the MSB down; zero upper bits leave the result unchanged.
    function automatic ptr_word_t gray2bin(input ptr_word_t gray);
        ptr_word_t bin;
        bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/ptr_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing into this domain.
module ptr_sync #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_ptr,
    output logic [WIDTH-1:0] sync_ptr
);

    logic [WIDTH-1:0] sync_q [STAGES];

    // Shift the incoming pointer through the flop chain; reset clears every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= async_ptr;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_ptr = sync_q[STAGES-1];

endmodule

// File: rtl/write_ptr_flag_ctrl.sv
// Write-side pointer and flag control of an asynchronous FIFO: binary/Gray
// write pointer, synchronized read pointer, full/almost-full flags, free-slot
// count and a sticky overflow error.
module write_ptr_flag_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH      = 5,
    parameter int SYNC_STAGES     = 2,
    parameter int ALMOST_FULL_LVL = 4
) (
    input  logic                  CLK_WRITE,
    input  logic                  WR_RST,
    input  logic                  WR_EN,
    input  logic [ADDR_WIDTH:0]   rptr_gray_async,
    input  logic                  OVF_CLR,
    output logic [ADDR_WIDTH-1:0] ADDR_WR,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic                  WR_ACK,
    output logic                  FULL_FLAG,
    output logic                  ALMOST_FULL,
    output logic [ADDR_WIDTH:0]   FREE_CNT,
    output logic                  OVF_ERR
);

    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    localparam logic [PTR_W-1:0] DEPTH_CNT = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AF_LVL    = PTR_W'(ALMOST_FULL_LVL);
    // Full when the Gray write pointer equals the read pointer with its two
    // MSBs flipped, i.e. exactly one lap ahead.
    localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (PTR_W - 2);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES must be in 2..4");
    end
    if (ALMOST_FULL_LVL < 1 || ALMOST_FULL_LVL > DEPTH - 1) begin : g_bad_af
        $error("ALMOST_FULL_LVL must be in 1..DEPTH-1");
    end

    logic [PTR_W-1:0] wbin;
    logic [PTR_W-1:0] wbin_next;
    logic [PTR_W-1:0] wgray_next;
    logic [PTR_W-1:0] rsync;
    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] used_next;
    logic [PTR_W-1:0] free_next;
    logic             full_next;
    logic             almost_next;

    ptr_sync #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk       (CLK_WRITE),
        .rst       (WR_RST),
        .async_ptr (rptr_gray_async),
        .sync_ptr  (rsync)
    );

    // Accept is combinational so it can drive the RAM write enable directly.
    assign WR_ACK  = WR_EN & ~FULL_FLAG & ~WR_RST;
    assign ADDR_WR = wbin[ADDR_WIDTH-1:0];

    // Next-state pointer and flag values; both a write and a read-pointer
    // move in the same cycle land in these results.
    always_comb begin
        wbin_next   = wbin + PTR_W'(WR_ACK);
        wgray_next  = PTR_W'(bin2gray(ptr_word_t'(wbin_next)));
        rbin        = PTR_W'(gray2bin(ptr_word_t'(rsync)));
        used_next   = wbin_next - rbin;
        free_next   = DEPTH_CNT - used_next;
        full_next   = (wgray_next == (rsync ^ FULL_MASK));
        almost_next = (free_next <= AF_LVL) | full_next;
    end

    // Pointer and status registers, all updated from the next-state values.
    always_ff @(posedge CLK_WRITE) begin
        if (WR_RST) begin
            wbin        <= '0;
            wptr_gray   <= '0;
            FULL_FLAG   <= 1'b0;
            ALMOST_FULL <= 1'b0;
            FREE_CNT    <= DEPTH_CNT;
        end else begin
            wbin        <= wbin_next;
            wptr_gray   <= wgray_next;
            FULL_FLAG   <= full_next;
            ALMOST_FULL <= almost_next;
            FREE_CNT    <= free_next;
        end
    end

    // Sticky overflow: a write attempt while full sets it and beats a clear.
    always_ff @(posedge CLK_WRITE) begin
        if (WR_RST) begin
            OVF_ERR <= 1'b0;
        end else if (WR_EN && FULL_FLAG) begin
            OVF_ERR <= 1'b1;
        end else if (OVF_CLR) begin
            OVF_ERR <= 1'b0;
        end
    end

endmodule

// File: tb/tb_write_ptr_flag_ctrl.sv
// Self-checking bench for write_ptr_flag_ctrl: directed scenarios plus random
// traffic compared against an occupancy-based reference model.
module tb_write_ptr_flag_ctrl;

    localparam int AW    = 5;
    localparam int SS    = 2;
    localparam int AFL   = 4;
    localparam int DEPTH = 32;
    localparam int PMOD  = 64;

    logic          CLK_WRITE = 1'b0;
    logic          WR_RST;
    logic          WR_EN;
    logic [AW:0]   rptr_gray_async;
    logic          OVF_CLR;
    logic [AW-1:0] ADDR_WR;
    logic [AW:0]   wptr_gray;
    logic          WR_ACK;
    logic          FULL_FLAG;
    logic          ALMOST_FULL;
    logic [AW:0]   FREE_CNT;
    logic          OVF_ERR;

    write_ptr_flag_ctrl #(
        .ADDR_WIDTH      (AW),
        .SYNC_STAGES     (SS),
        .ALMOST_FULL_LVL (AFL)
    ) dut (
        .CLK_WRITE       (CLK_WRITE),
        .WR_RST          (WR_RST),
        .WR_EN           (WR_EN),
        .rptr_gray_async (rptr_gray_async),
        .OVF_CLR         (OVF_CLR),
        .ADDR_WR         (ADDR_WR),
        .wptr_gray       (wptr_gray),
        .WR_ACK          (WR_ACK),
        .FULL_FLAG       (FULL_FLAG),
        .ALMOST_FULL     (ALMOST_FULL),
        .FREE_CNT        (FREE_CNT),
        .OVF_ERR         (OVF_ERR)
    );

    always #5 CLK_WRITE = ~CLK_WRITE;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: write count, read count, and the read counts the
    // write domain can currently see (oldest last).
    int m_w;
    int m_r;
    int m_hist [SS];
    bit m_full;
    bit m_af;
    bit m_ovf;
    int m_free;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic step(input bit en, input bit rd, input bit clr, input bit rst, output bit acked);
        int occ;
        int w_next;
        int rs;
        bit ack;
        if (rst) m_r = 0;
        else if (rd && m_r != m_w) m_r = (m_r + 1) % PMOD;
        WR_EN           = en;
        OVF_CLR         = clr;
        WR_RST          = rst;
        rptr_gray_async = 6'(m_r ^ (m_r >> 1));
        ack = en && !m_full && !rst;
        #1;
        chk("wr_ack", 32'(WR_ACK), 32'(ack));
        @(posedge CLK_WRITE);
        if (rst) begin
            m_w = 0;
            for (int i = 0; i < SS; i++) m_hist[i] = 0;
            m_full = 0;
            m_af   = 0;
            m_ovf  = 0;
            m_free = DEPTH;
        end else begin
            rs     = m_hist[SS-1];
            w_next = (m_w + int'(ack)) % PMOD;
            occ    = (w_next - rs + PMOD) % PMOD;
            m_ovf  = (en && m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
            m_full = (occ == DEPTH);
            m_free = DEPTH - occ;
            m_af   = (m_free <= AFL) || m_full;
            for (int i = SS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = m_r;
            m_w = w_next;
        end
        #1;
        chk("addr_wr",     32'(ADDR_WR),     32'(m_w % DEPTH));
        chk("wptr_gray",   32'(wptr_gray),   32'(m_w ^ (m_w >> 1)));
        chk("full_flag",   32'(FULL_FLAG),   32'(m_full));
        chk("almost_full", 32'(ALMOST_FULL), 32'(m_af));
        chk("free_cnt",    32'(FREE_CNT),    32'(m_free));
        chk("ovf_err",     32'(OVF_ERR),     32'(m_ovf));
        acked = ack;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bit a;
        int acks;
        logic [AW:0]   prev_gray;
        logic [AW-1:0] prev_addr;
        bit seen_wrap;

        m_w = 0; m_r = 0; m_full = 0; m_af = 0; m_ovf = 0; m_free = DEPTH;
        for (int i = 0; i < SS; i++) m_hist[i] = 0;

        // Reset state
        step(1, 0, 0, 1, a);
        step(0, 0, 0, 1, a);
        chk("rst_free", 32'(FREE_CNT), 32);
        chk("rst_full", 32'(FULL_FLAG), 0);

        // Almost-full threshold
        for (int i = 0; i < 27; i++) step(1, 0, 0, 0, a);
        chk("af27_free", 32'(FREE_CNT), 5);
        chk("af27_flag", 32'(ALMOST_FULL), 0);
        step(1, 0, 0, 0, a);
        chk("af28_free", 32'(FREE_CNT), 4);
        chk("af28_flag", 32'(ALMOST_FULL), 1);

        // Fill to full and overflow
        step(0, 0, 0, 1, a);
        acks = 0;
        for (int i = 1; i <= 34; i++) begin
            step(1, 0, 0, 0, a);
            acks += int'(a);
            if (i == 32) begin
                chk("fill_full32", 32'(FULL_FLAG), 1);
                chk("fill_ovf32",  32'(OVF_ERR), 0);
            end
        end
        chk("fill_acks", 32'(acks), 32);
        chk("fill_full", 32'(FULL_FLAG), 1);
        chk("fill_free", 32'(FREE_CNT), 0);
        chk("fill_ovf",  32'(OVF_ERR), 1);

        // Release after one read crosses the synchronizer
        step(0, 1, 0, 0, a);
        step(0, 0, 0, 0, a);
        step(0, 0, 0, 0, a);
        chk("rel_full", 32'(FULL_FLAG), 0);
        chk("rel_free", 32'(FREE_CNT), 1);
        step(1, 0, 0, 0, a);
        chk("rel_ack", 32'(a), 1);

        // Reset mid-fill, then clear colliding with a new overflow
        step(0, 0, 0, 1, a);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, a);
        step(1, 0, 0, 1, a);
        chk("mid_rst_addr", 32'(ADDR_WR), 0);
        chk("mid_rst_gray", 32'(wptr_gray), 0);
        chk("mid_rst_free", 32'(FREE_CNT), 32);
        chk("mid_rst_full", 32'(FULL_FLAG), 0);
        chk("mid_rst_af",   32'(ALMOST_FULL), 0);
        chk("mid_rst_ovf",  32'(OVF_ERR), 0);
        for (int i = 0; i < 33; i++) step(1, 0, 0, 0, a);
        step(1, 0, 1, 0, a);
        chk("clr_vs_set", 32'(OVF_ERR), 1);
        step(0, 0, 1, 0, a);
        chk("clr_only", 32'(OVF_ERR), 0);

        // Pointer wrap with the reader keeping pace
        step(0, 0, 0, 1, a);
        seen_wrap = 0;
        prev_gray = wptr_gray;
        prev_addr = ADDR_WR;
        for (int i = 0; i < 70; i++) begin
            step(1, 1, 0, 0, a);
            if (a && m_w == 0 && !seen_wrap) begin
                seen_wrap = 1;
                chk("wrap_gray_prev", 32'(prev_gray), 32'h20);
                chk("wrap_addr_prev", 32'(prev_addr), 31);
                chk("wrap_gray",      32'(wptr_gray), 0);
                chk("wrap_addr",      32'(ADDR_WR), 0);
            end
            prev_gray = wptr_gray;
            prev_addr = ADDR_WR;
        end
        chk("wrap_seen", 32'(seen_wrap), 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0, a);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
